// File: rtl/debounce_pkg.sv
// Shared defaults and limits for the debounce bank and its per-channel slices.
// No logic here beyond a constant helper.
// Imported by debounce_ch and debounce_bank.
package debounce_pkg;

  localparam int   CH_DEFAULT      = 4;
  localparam int   CH_MAX          = 32;
  localparam int   CNT_W_DEFAULT   = 20;
  localparam logic RST_VAL_DEFAULT = 1'b0;

  // Number of tick strobes a level must hold before it is accepted.
  function automatic longint unsigned stable_ticks(input int cnt_w);
    return longint'(1) << cnt_w;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: two-flop synchroniser, stability counter, level and edge pulses.
// Latency: a clean step reaches out_o 2^CNT_W+2 edges after it is first sampled (tick held 1).
// No backpressure; tick_i only paces the counter.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int   CNT_W   = CNT_W_DEFAULT,
  parameter logic RST_VAL = RST_VAL_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic in_i,
  output logic out_o,
  output logic onup_o,
  output logic ondn_o
);

  logic             s0_q;
  logic             s1_q;
  logic             out_q;
  logic             out_d;
  logic             onup_q;
  logic             onup_d;
  logic             ondn_q;
  logic             ondn_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count ticks while the synchronised level disagrees with out; flip when the counter saturates.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    onup_d = 1'b0;
    ondn_d = 1'b0;
    if (s1_q == out_q) begin
      // Idle or a bounce back to the accepted level: drop any partial credit.
      cnt_d = '0;
    end else if (tick_i) begin
      if (&cnt_q) begin
        cnt_d  = '0;
        out_d  = ~out_q;
        onup_d = ~out_q;
        ondn_d = out_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser and channel state registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q   <= RST_VAL;
      s1_q   <= RST_VAL;
      out_q  <= RST_VAL;
      cnt_q  <= '0;
      onup_q <= 1'b0;
      ondn_q <= 1'b0;
    end else begin
      s0_q   <= in_i;
      s1_q   <= s0_q;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      onup_q <= onup_d;
      ondn_q <= ondn_d;
    end
  end

  assign out_o  = out_q;
  assign onup_o = onup_q;
  assign ondn_o = ondn_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of CH independent debounce channels plus a registered any-event flag.
// Latency: any_evt follows an onup/ondn pulse by one cycle.
// No backpressure; tick paces all channel counters together.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   CH      = CH_DEFAULT,
  parameter int   CNT_W   = CNT_W_DEFAULT,
  parameter logic RST_VAL = RST_VAL_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [CH-1:0] in,
  output logic [CH-1:0] out,
  output logic [CH-1:0] onup,
  output logic [CH-1:0] ondn,
  output logic          any_evt
);

  logic any_evt_q;
  logic any_evt_d;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    debounce_ch #(
      .CNT_W   (CNT_W),
      .RST_VAL (RST_VAL)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick_i (tick),
      .in_i   (in[i]),
      .out_o  (out[i]),
      .onup_o (onup[i]),
      .ondn_o (ondn[i])
    );
  end

  // Any channel reporting an edge this cycle.
  always_comb begin
    any_evt_d = |(onup | ondn);
  end

  // Register the summary flag so it trails the per-channel pulses by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_evt_q <= 1'b0;
    end else begin
      any_evt_q <= any_evt_d;
    end
  end

  assign any_evt = any_evt_q;

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent input channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 20: stability counter width; stable period is 2^CNT_W ticks.
REQ-003 SHALL have parameter RST_VAL, default 1'b0: reset/idle level of every channel.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on posedge clk.
REQ-005 SHALL have port rst, input, 1: reset, synchronous to clk, active-high.
REQ-006 SHALL have port tick, input, 1: counter advance strobe; tie to 1 for per-clock counting.
REQ-007 SHALL have port in, input, CH: raw asynchronous inputs, bit i = channel i.
REQ-008 SHALL have port out, output, CH: debounced levels.
REQ-009 SHALL have port onup, output, CH: one-cycle pulse, out[i] rose.
REQ-010 SHALL have port ondn, output, CH: one-cycle pulse, out[i] fell.
REQ-011 SHALL have port any_evt, output, 1: registered OR of onup|ondn.

Function
REQ-012 Each channel SHALL pass in[i] through a two-flop synchroniser (s0, s1) before any use.
REQ-013 Channel idle SHALL be (s1 == out[i]); an idle channel SHALL clear its counter to 0 every cycle regardless of tick.
REQ-014 A non-idle channel with tick=1 SHALL increment its CNT_W-bit counter; tick=0 SHALL hold it.
REQ-015 When non-idle, tick=1 and counter all-ones, out[i] SHALL invert at that edge and the counter SHALL wrap to 0.
REQ-016 With tick held 1, a clean input step SHALL appear on out[i] exactly 2^CNT_W+2 clk edges after the first edge sampling the new level.
REQ-017 Any return of s1 to out[i] before the toggle SHALL clear the counter; no partial credit is kept.
REQ-018 onup[i]/ondn[i] SHALL be registered, asserted in the same cycle out[i] shows its new value, for exactly one cycle.
REQ-019 onup[i] and ondn[i] SHALL never assert together.
REQ-020 any_evt SHALL assert one cycle after any onup/ondn bit, for one cycle per event cycle.
REQ-021 Channels SHALL be fully independent; simultaneous toggles on several channels SHALL all be reported in the same cycle.

Reset
REQ-022 With rst=1 at a clk edge: s0, s1, out all set to RST_VAL, counters 0, onup/ondn/any_evt 0.
REQ-023 rst SHALL override tick and any in-progress count; no event pulse SHALL be produced by reset.
REQ-024 After rst deasserts with in held at RST_VAL, no output SHALL change.

Structure
REQ-025 Default parameter values and the maximum CH limit SHALL live in shared package debounce_pkg.
REQ-026 Per-channel logic (synchroniser, counter, out, edge pulses) SHALL be sub-module debounce_ch, instantiated CH times by generate; debounce_bank adds only any_evt.

Verification (CH=2, CNT_W=3, RST_VAL=0, tick=1 unless stated)
REQ-027 in[0] 0->1 held: out[0] rises exactly 10 edges later, onup[0]=1 that cycle only, any_evt=1 next cycle; channel 1 unaffected.
REQ-028 in[0] high for 6 cycles then low: out[0] stays 0, no onup/ondn pulse.
REQ-029 in=2'b11 stepped together: both out bits rise same cycle, onup=2'b11 for one cycle; later in=2'b00 gives ondn=2'b11 after 10 edges.
REQ-030 tick asserted every 4th cycle, in[1] 0->1: out[1] rises after 8 ticks plus sync/count-alignment delay; counter value frozen on tick=0 cycles.
REQ-031 rst pulsed mid-count (counter=5) on in[0]: counter 0, out 0, no pulse; after release with in[0]=1 still held, full 10-edge delay recurs before out[0] rises.
